// File: rtl/vpi_net_pkg.sv
// Shared types, constants and pattern function for the VPI net pattern generator.
// Optional watchdog macro: VPI_NET_PATTERN_TIMEOUT_EN.
package vpi_net_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRIVE,
    S_HOLD,
    S_DONE
  } state_e;

  localparam logic [7:0] ERR_MAX       = 8'd255;
  // Watchdog value reached on the 256th consecutive DRIVE cycle.
  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;
  localparam int unsigned PAT_MAX_W    = 64;

  // Element e of pattern k is (k+e) mod 2^width, inverted for odd k; element 0 in the LSBs.
  function automatic logic [PAT_MAX_W-1:0] pattern_of(input logic [7:0]  k,
                                                      input int unsigned width,
                                                      input int unsigned depth);
    logic [PAT_MAX_W-1:0] mask;
    logic [PAT_MAX_W-1:0] elem;
    logic [PAT_MAX_W-1:0] res;
    mask = (PAT_MAX_W'(1) << width) - PAT_MAX_W'(1);
    res  = '0;
    for (int unsigned e = 0; e < depth; e++) begin
      elem = (PAT_MAX_W'(k) + PAT_MAX_W'(e)) & mask;
      if (k[0]) elem = ~elem & mask;
      res = res | (elem << (e * width));
    end
    return res;
  endfunction

endpackage

// File: rtl/vpi_net_sat_cnt.sv
// 8-bit saturating up-counter with synchronous clear (clear wins over increment).
module vpi_net_sat_cnt
  import vpi_net_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] cnt
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != ERR_MAX)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/vpi_net_pattern_gen.sv
// Pattern generator: drives NPAT patterns with a valid/ack handshake, checks the
// echoed readback and keeps a saturating error count.
// Optional DRIVE watchdog enabled by defining VPI_NET_PATTERN_TIMEOUT_EN.
module vpi_net_pattern_gen
  import vpi_net_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned NPAT  = 8,
  parameter int unsigned HOLD  = 2
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [DEPTH*WIDTH-1:0] pat_o,
  output logic                   pat_valid,
  input  logic                   pat_ack,
  input  logic [DEPTH*WIDTH-1:0] rd_back,
  output logic [7:0]             pat_idx,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             err_cnt,
  output logic                   err
);

  localparam int unsigned PAT_W  = DEPTH * WIDTH;
  localparam int unsigned HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_o_q, pat_o_d;
  logic               pat_valid_q, pat_valid_d;
  logic [7:0]         pat_idx_q, pat_idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               err_inc;
  logic               err_clr;
  logic               timeout;
  logic               last_pat;

  assign last_pat = (pat_idx_q == 8'(NPAT - 1));

`ifdef VPI_NET_PATTERN_TIMEOUT_EN
  logic [7:0] wd_cnt;

  // Watchdog counts DRIVE cycles and restarts on every LOAD.
  vpi_net_sat_cnt u_wdog (
    .clk   (clk),
    .reset (reset),
    .inc   (state_q == S_DRIVE),
    .clr   (state_q == S_LOAD),
    .cnt   (wd_cnt)
  );

  assign timeout = (state_q == S_DRIVE) && (wd_cnt == TIMEOUT_LIMIT);
`else
  assign timeout = 1'b0;
`endif

  // Mismatch counter; cleared when a new run starts.
  vpi_net_sat_cnt u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc),
    .clr   (err_clr),
    .cnt   (err_cnt)
  );

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    pat_o_d    = pat_o_q;
    pat_idx_d  = pat_idx_q;
    err_d      = err_q;
    hold_cnt_d = hold_cnt_q;
    err_inc    = 1'b0;
    err_clr    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_LOAD;
          pat_idx_d = '0;
          err_d     = 1'b0;
          err_clr   = 1'b1;
        end
      end
      S_LOAD: begin
        pat_o_d    = PAT_W'(pattern_of(pat_idx_q, WIDTH, DEPTH));
        hold_cnt_d = '0;
        state_d    = S_DRIVE;
      end
      S_DRIVE: begin
        if (pat_ack || timeout) begin
          // An ack takes priority over a coincident timeout.
          if (!pat_ack || (rd_back != pat_o_q)) begin
            err_inc = 1'b1;
            err_d   = 1'b1;
          end
          if (HOLD == 0) begin
            if (last_pat) begin
              state_d = S_DONE;
            end else begin
              pat_idx_d = pat_idx_q + 8'd1;
              state_d   = S_LOAD;
            end
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == HOLD_W'(HOLD - 1)) begin
          if (last_pat) begin
            state_d = S_DONE;
          end else begin
            pat_idx_d = pat_idx_q + 8'd1;
            state_d   = S_LOAD;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    pat_valid_d = (state_d == S_DRIVE);
    busy_d      = (state_d == S_LOAD) || (state_d == S_DRIVE) || (state_d == S_HOLD);
    done_d      = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pat_o_q     <= '0;
      pat_valid_q <= 1'b0;
      pat_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pat_o_q     <= pat_o_d;
      pat_valid_q <= pat_valid_d;
      pat_idx_q   <= pat_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign pat_o     = pat_o_q;
  assign pat_valid = pat_valid_q;
  assign pat_idx   = pat_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_vpi_net_pattern_gen.sv
// Bench for vpi_net_pattern_gen: two instances (default NPAT=8/HOLD=2 and
// NPAT=256/HOLD=0) exercised by a consumer with random ack delays and corruption.
module tb_vpi_net_pattern_gen;

  localparam int WIDTH = 2;
  localparam int DEPTH = 3;
  localparam int PW    = WIDTH * DEPTH;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          pat_ack = 1'b0;
  logic [PW-1:0] rd_back = '0;
  logic          sel = 1'b0;

  logic [PW-1:0] pat_a, pat_b, v_pat;
  logic          valid_a, valid_b, v_valid;
  logic [7:0]    idx_a, idx_b, v_idx;
  logic          busy_a, busy_b, v_busy;
  logic          done_a, done_b, v_done;
  logic [7:0]    ec_a, ec_b, v_ec;
  logic          err_a, err_b, v_err;
  logic          start_a, start_b;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cur_npat = 8;
  int cur_hold = 2;

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  vpi_net_pattern_gen #(.WIDTH(2), .DEPTH(3), .NPAT(8), .HOLD(2)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .pat_o(pat_a), .pat_valid(valid_a),
    .pat_ack(pat_ack), .rd_back(rd_back), .pat_idx(idx_a), .busy(busy_a),
    .done(done_a), .err_cnt(ec_a), .err(err_a));

  vpi_net_pattern_gen #(.WIDTH(2), .DEPTH(3), .NPAT(256), .HOLD(0)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .pat_o(pat_b), .pat_valid(valid_b),
    .pat_ack(pat_ack), .rd_back(rd_back), .pat_idx(idx_b), .busy(busy_b),
    .done(done_b), .err_cnt(ec_b), .err(err_b));

  assign v_pat   = sel ? pat_b   : pat_a;
  assign v_valid = sel ? valid_b : valid_a;
  assign v_idx   = sel ? idx_b   : idx_a;
  assign v_busy  = sel ? busy_b  : busy_a;
  assign v_done  = sel ? done_b  : done_a;
  assign v_ec    = sel ? ec_b    : ec_a;
  assign v_err   = sel ? err_b   : err_a;

  // Reference pattern built element by element from the arithmetic rule.
  function automatic logic [63:0] model_pat(input int k);
    longint v;
    longint acc;
    acc = 0;
    for (int e = 0; e < DEPTH; e++) begin
      v = longint'((k + e) % (1 << WIDTH));
      if ((k % 2) == 1) v = longint'((1 << WIDTH) - 1) - v;
      acc = acc + v * (longint'(1) << (WIDTH * e));
    end
    return 64'(acc);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full run on the selected instance. mode 0: clean, 1: corrupt pattern 3, 2: random corruption.
  task automatic run(input int mode);
    int          n;
    int          d;
    int          exp_err;
    bit          bad;
    logic [63:0] exp_p;
    exp_err = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_busy", 64'(v_busy), 64'd1);
    chk("start_done", 64'(v_done), 64'd0);
    chk("start_clr_err", {55'd0, v_err, v_ec}, 64'd0);
    chk("start_idx", 64'(v_idx), 64'd0);
    for (int k = 0; k < cur_npat; k++) begin
      exp_p = model_pat(k);
      n = 0;
      while (!v_valid && n < 64) begin tick; n++; end
      chk("valid_gap", 64'(n), (k == 0) ? 64'd1 : 64'(cur_hold + 1));
      chk("pat_o", 64'(v_pat), exp_p);
      chk("pat_idx", 64'(v_idx), 64'(k));
      d = int'($urandom_range(0, 3));
      repeat (d) tick;
      chk("hold_stable", {57'd0, v_valid, v_pat}, {57'd0, 1'b1, exp_p[PW-1:0]});
      bad = (mode == 1 && k == 3) || (mode == 2 && $urandom_range(0, 1) == 1);
      pat_ack = 1'b1;
      rd_back = exp_p[PW-1:0] ^ PW'(bad);
      start   = (k == 4);
      tick;
      pat_ack = 1'b0;
      start   = 1'b0;
      rd_back = PW'($urandom);
      if (bad && exp_err < 255) exp_err++;
      chk("valid_drop", 64'(v_valid), 64'd0);
      chk("err_cnt_run", 64'(v_ec), 64'(exp_err));
    end
    n = 0;
    while (!v_done && n < 64) begin tick; n++; end
    chk("done_lat", 64'(n), 64'(cur_hold));
    chk("done_busy", {62'd0, v_done, v_busy}, 64'b10);
    chk("final_err_cnt", 64'(v_ec), 64'(exp_err));
    chk("final_err", 64'(v_err), 64'(exp_err != 0));
    chk("final_idx", 64'(v_idx), 64'(cur_npat - 1));
  endtask

  initial begin
    int n;
    #1;
    chk("reset_async_a", {pat_a, valid_a, idx_a, busy_a, done_a, ec_a, err_a}, '0);
    tick;
    tick;
    chk("reset_a", {pat_a, valid_a, idx_a, busy_a, done_a, ec_a, err_a}, '0);
    chk("reset_b", {pat_b, valid_b, idx_b, busy_b, done_b, ec_b, err_b}, '0);
    @(negedge clk);
    reset = 1'b0;
    tick;

    sel = 1'b0; cur_npat = 8; cur_hold = 2;
    run(0);
    run(1);
    run(2);

    // Reset asserted in the DRIVE phase of pattern 2.
    start = 1'b1; tick; start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!v_valid && n < 64) begin tick; n++; end
      pat_ack = 1'b1;
      rd_back = PW'(model_pat(k));
      tick;
      pat_ack = 1'b0;
    end
    n = 0;
    while (!v_valid && n < 64) begin tick; n++; end
    chk("mid_idx", 64'(v_idx), 64'd2);
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_async", {pat_a, valid_a, idx_a, busy_a, done_a, ec_a, err_a}, '0);
    @(negedge clk);
    reset = 1'b0;
    tick;
    run(0);

    // Long run, ack held high, every echo wrong.
    sel = 1'b1; cur_npat = 256; cur_hold = 0;
    pat_ack = 1'b1;
    start = 1'b1; tick; start = 1'b0;
    for (int k = 0; k < 256; k++) begin
      rd_back = PW'(model_pat(k)) ^ PW'(1);
      tick;
      chk("sat_drive", {49'd0, v_valid, v_idx, v_pat}, {49'd0, 1'b1, 8'(k), PW'(model_pat(k))});
      chk("sat_cnt", 64'(v_ec), 64'(k));
      tick;
    end
    pat_ack = 1'b0;
    chk("sat_final", {53'd0, v_done, v_busy, v_err, v_ec}, {53'd0, 1'b1, 1'b0, 1'b1, 8'd255});
    start = 1'b1; tick; start = 1'b0;
    chk("done_start_clr", {53'd0, v_done, v_busy, v_err, v_ec}, {53'd0, 1'b0, 1'b1, 1'b0, 8'd0});
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tick;

`ifdef VPI_NET_PATTERN_TIMEOUT_EN
    // Never acknowledge: every pattern times out.
    sel = 1'b0; cur_npat = 8; cur_hold = 2;
    start = 1'b1; tick; start = 1'b0;
    n = 0;
    while (!v_valid && n < 64) begin tick; n++; end
    n = 0;
    while (v_valid && n < 400) begin tick; n++; end
    chk("timeout_len", 64'(n), 64'd256);
    n = 0;
    while (!v_done && n < 4000) begin tick; n++; end
    chk("timeout_final", {54'd0, v_done, v_err, v_ec}, {54'd0, 1'b1, 1'b1, 8'd8});
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vpi_net_pattern_gen.md
Name: vpi_net_pattern_gen

Overview:
- Upstream stimulus stage for the VPI net-model regressions.
- Produces a sequence of packed-array patterns on a public net bus, which the VPI/DPI checker reads and echoes back.
- Handshakes each pattern, compares the echoed readback against the expected value and accumulates an error count.
- Supplies the time-varying values that the net-model consumer inspects through `public_flat_rw @(posedge clk)` signals.

Parameters:
- WIDTH, 2: bits per element.
- DEPTH, 3: elements per pattern; element 0 occupies the LSBs.
- NPAT, 8: number of patterns per run; must be 1..256.
- HOLD, 2: idle cycles between patterns, with pat_valid low; 0 is legal.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a run from IDLE or DONE, ignored otherwise.
- pat_o  output  DEPTH*WIDTH  current pattern.
- pat_valid  output  1  pat_o is stable and presented for checking.
- pat_ack  input  1  consumer has read pat_o and driven rd_back.
- rd_back  input  DEPTH*WIDTH  echoed value, sampled in the cycle pat_ack is high.
- pat_idx  output  8  index of the current pattern.
- busy  output  1  high in any state other than IDLE or DONE.
- done  output  1  run complete.
- err_cnt  output  8  saturating mismatch count.
- err  output  1  sticky: err_cnt != 0, or a timeout has occurred.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; pat_o=0, pat_valid=0, pat_idx=0, busy=0, done=0, err_cnt=0, err=0.
  - Asserting reset mid-run aborts immediately; no partial update is kept.
- Pattern function: element e of pattern k = ((k+e) mod 2^WIDTH).
  - If k is odd, each element is additionally bitwise-inverted.
  - Computed from pat_idx in LOAD and registered into pat_o.
- State machine:
  - IDLE --start--> LOAD.
  - LOAD (1 cycle): register pat_o, then go to DRIVE.
  - DRIVE: pat_valid=1, pat_o held stable.
    - pat_ack high: sample rd_back; if rd_back != pat_o, increment err_cnt (saturates at 255) and set err.
    - Same edge: pat_valid drops and the FSM goes to HOLD.
  - HOLD: count HOLD cycles; if HOLD=0, the FSM spends zero cycles here. Then:
    - If pat_idx == NPAT-1: go to DONE.
    - Otherwise: pat_idx++ and go to LOAD.
  - DONE: done=1, busy=0; pat_o keeps its last value.
    - start → clear done, err_cnt, err and pat_idx, then go to LOAD.
- Ack handling:
  - pat_ack outside DRIVE is ignored.
  - pat_ack already high on DRIVE entry is accepted in the first DRIVE cycle.
  - Minimum per-pattern latency is 2+HOLD cycles (LOAD, one DRIVE cycle, HOLD).
- Wrap: pat_idx never wraps within a run.
- start while busy is ignored.
- err_cnt and err persist through DONE until the next start or reset.

Optional Feature:
- Macro: VPI_NET_PATTERN_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog counts cycles spent in DRIVE.
  - After 256 cycles without pat_ack: set err, increment err_cnt (saturating), drop pat_valid and go to HOLD as if the pattern had been acked.
  - The watchdog clears on every LOAD.
- Undefined: no watchdog; DRIVE waits indefinitely; no timeout logic is present.

Decomposition:
- Package vpi_net_pkg:
  - state enum {IDLE, LOAD, DRIVE, HOLD, DONE}.
  - ERR_MAX = 8'd255.
  - Timeout limit constant.
  - Function pattern_of(k, WIDTH, DEPTH).
- One sub-module, vpi_net_sat_cnt: an 8-bit saturating counter with inc/clr, used for err_cnt and the watchdog.

Test Plan:
- Basic walk, defaults, consumer echoes pat_o with ack 1 cycle after valid:
  - pat_o sequence 0x24, 0x06, ... across 8 patterns.
  - done after the last HOLD; err_cnt=0, err=0.
- Mismatch: corrupt rd_back on pattern 3 only (echo XOR 1) → err_cnt=1, err=1, done=1, pat_idx=7.
- Saturation: NPAT=256, every echo wrong → err_cnt stays 255, no wrap; done=1.
- Reset mid-run: assert reset during DRIVE of pattern 2 → all outputs 0 asynchronously, before the next clk; a later start restarts at pat_idx=0 with pat_o=0x24.
- Ack/start edge cases: pat_ack held high continuously with HOLD=0 → each pattern takes 2 cycles; start pulses during busy are ignored; start in DONE clears err_cnt.
- Timeout (VPI_NET_PATTERN_TIMEOUT_EN defined), never ack → each pattern times out after 256 DRIVE cycles; final err_cnt=8, err=1, done=1.
